// File: rtl/jtag_er_pkg.sv
// jtag_er_pkg -- shared definitions for the JTAG user-data-register bridge.
//   * chan_state_e : per-channel FSM state encoding
//   * NUM_CH_MIN/MAX, DATA_W_MIN/MAX : legal parameter ranges
//   * SYNC_DEPTH   : flop count of every JTAG-to-fabric synchroniser
// Optional feature macro (used by the channel): JTAG_ER_BRIDGE_PARITY_EN
package jtag_er_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_UPDATE  = 2'd3
  } chan_state_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 4;
  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 32;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/jtag_er_chan.sv
// jtag_er_chan -- one JTAG user-data-register channel.
// Runs entirely in the fabric clock domain on already-synchronised JTAG
// strobes: capture from a fabric-written holding register, serial shift,
// update into a valid/ready output register, sticky overflow flag.
// Ports:
//   clk_i, rst_ni      fabric clock, asynchronous active-low reset
//   jrst_i             synchronous clear from JTAG reset (active high)
//   tck_rise_i         1-cycle pulse per synchronised JTCK rising edge
//   upd_rise_i         1-cycle pulse per synchronised JUPDATE rising edge
//   jtdi_i, jshift_i   synchronised TDI and SHIFT
//   jce_i              synchronised channel enable
//   cap_data_i/cap_we_i   capture holding register write
//   upd_data_o/upd_valid_o/upd_ready_i   update handshake
//   ovf_o              sticky overflow / bad-parity flag
//   jtdo_o             registered serial return (shift register bit 0)
// Macro JTAG_ER_BRIDGE_PARITY_EN adds an even-parity bit above the payload.
module jtag_er_chan
  import jtag_er_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              jrst_i,
  input  logic              tck_rise_i,
  input  logic              upd_rise_i,
  input  logic              jtdi_i,
  input  logic              jshift_i,
  input  logic              jce_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic              cap_we_i,
  input  logic              upd_ready_i,
  output logic [DATA_W-1:0] upd_data_o,
  output logic              upd_valid_o,
  output logic              ovf_o,
  output logic              jtdo_o
);

`ifdef JTAG_ER_BRIDGE_PARITY_EN
  localparam int SR_W = DATA_W + 1;
`else
  localparam int SR_W = DATA_W;
`endif

  chan_state_e       state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] upd_data_q, upd_data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              jtdo_q;

  logic [SR_W-1:0]   cap_word;
  logic              par_ok;

`ifdef JTAG_ER_BRIDGE_PARITY_EN
  // Top bit makes the whole word even parity.
  assign cap_word = {^hold_q, hold_q};
  assign par_ok   = (sr_q[DATA_W] == ^sr_q[DATA_W-1:0]);
`else
  assign cap_word = hold_q;
  assign par_ok   = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    hold_d     = cap_we_i ? cap_data_i : hold_q;
    upd_data_d = upd_data_q;
    // A sampled ready completes the handshake on this edge.
    valid_d    = valid_q & ~upd_ready_i;
    ovf_d      = ovf_q;

    if (jrst_i) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (upd_rise_i && (state_q == ST_SHIFT)) begin
      state_d = ST_UPDATE;
      if (!par_ok) begin
        ovf_d = 1'b1;
      end else if (valid_q && !upd_ready_i) begin
        // Consumer still holds the previous word: keep it, flag the loss.
        ovf_d = 1'b1;
      end else begin
        // Either empty or being drained this very edge: new word wins.
        upd_data_d = sr_q[DATA_W-1:0];
        valid_d    = 1'b1;
      end
    end else if (!jce_i) begin
      state_d = ST_IDLE;
    end else if (tck_rise_i) begin
      if (jshift_i) begin
        state_d = ST_SHIFT;
        sr_d    = {jtdi_i, sr_q[SR_W-1:1]};
      end else begin
        // hold_q is the pre-write value, so a coincident cap_we is not seen.
        state_d = ST_CAPTURE;
        sr_d    = cap_word;
      end
    end else if (state_q == ST_UPDATE) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      hold_q     <= '0;
      upd_data_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      jtdo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      upd_data_q <= upd_data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      jtdo_q     <= sr_q[0];
    end
  end

  assign upd_data_o  = upd_data_q;
  assign upd_valid_o = valid_q;
  assign ovf_o       = ovf_q;
  assign jtdo_o      = jtdo_q;

endmodule

// File: rtl/jtag_er_bridge.sv
// jtag_er_bridge -- bridges NUM_CH JTAG user data registers into the fabric
// clock domain. Holds the 2-flop synchronisers for all JTAG primitive
// signals, the JTCK/JUPDATE rising-edge detectors, and one jtag_er_chan
// per channel.
// Ports:
//   CLK, RSTN                         fabric clock, async active-low reset
//   JTCK, JTDI, JSHIFT, JUPDATE, JRSTN JTAG primitive outputs (async)
//   JCE[NUM_CH]                       per-channel enable (async)
//   JTDO[NUM_CH]                      per-channel serial return
//   cap_data/cap_we                   capture holding register writes
//   upd_data/upd_valid/upd_ready      update handshake per channel
//   ovf[NUM_CH]                       sticky overflow per channel
// Macro JTAG_ER_BRIDGE_PARITY_EN enables the per-channel parity bit.
// JTCK must run at most CLK/4 so every edge survives synchronisation.
module jtag_er_bridge
  import jtag_er_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     JTCK,
  input  logic                     JTDI,
  input  logic                     JSHIFT,
  input  logic                     JUPDATE,
  input  logic                     JRSTN,
  input  logic [NUM_CH-1:0]        JCE,
  output logic [NUM_CH-1:0]        JTDO,
  input  logic [NUM_CH*DATA_W-1:0] cap_data,
  input  logic [NUM_CH-1:0]        cap_we,
  output logic [NUM_CH*DATA_W-1:0] upd_data,
  output logic [NUM_CH-1:0]        upd_valid,
  input  logic [NUM_CH-1:0]        upd_ready,
  output logic [NUM_CH-1:0]        ovf
);

  localparam int SYNC_W = 5 + NUM_CH;

  logic [SYNC_W-1:0]                  sync_raw;
  logic [SYNC_DEPTH-1:0][SYNC_W-1:0]  sync_q;
  logic [SYNC_W-1:0]                  sync_s;
  logic                               tck_prev_q;
  logic                               upd_prev_q;

  logic              tck_s, tdi_s, shift_s, update_s, jrstn_s;
  logic [NUM_CH-1:0] jce_s;
  logic              tck_rise, upd_rise, jrst;

  assign sync_raw = {JCE, JRSTN, JUPDATE, JSHIFT, JTDI, JTCK};

  // All JTAG signals share one synchroniser chain so they stay aligned.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q     <= '0;
      tck_prev_q <= 1'b0;
      upd_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_DEPTH-2:0], sync_raw};
      tck_prev_q <= tck_s;
      upd_prev_q <= update_s;
    end
  end

  assign sync_s   = sync_q[SYNC_DEPTH-1];
  assign tck_s    = sync_s[0];
  assign tdi_s    = sync_s[1];
  assign shift_s  = sync_s[2];
  assign update_s = sync_s[3];
  assign jrstn_s  = sync_s[4];
  assign jce_s    = sync_s[SYNC_W-1:5];

  assign tck_rise = tck_s & ~tck_prev_q;
  assign upd_rise = update_s & ~upd_prev_q;
  assign jrst     = ~jrstn_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    jtag_er_chan #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk_i       (CLK),
      .rst_ni      (RSTN),
      .jrst_i      (jrst),
      .tck_rise_i  (tck_rise),
      .upd_rise_i  (upd_rise),
      .jtdi_i      (tdi_s),
      .jshift_i    (shift_s),
      .jce_i       (jce_s[c]),
      .cap_data_i  (cap_data[c*DATA_W +: DATA_W]),
      .cap_we_i    (cap_we[c]),
      .upd_ready_i (upd_ready[c]),
      .upd_data_o  (upd_data[c*DATA_W +: DATA_W]),
      .upd_valid_o (upd_valid[c]),
      .ovf_o       (ovf[c]),
      .jtdo_o      (JTDO[c])
    );
  end

endmodule

// File: tb/tb_jtag_er_bridge.sv
// Directed bench for jtag_er_bridge (NUM_CH=2, DATA_W=8).
// Builds with or without JTAG_ER_BRIDGE_PARITY_EN.
module tb_jtag_er_bridge;

`ifdef JTAG_ER_BRIDGE_PARITY_EN
  localparam int SRW = 9;
`else
  localparam int SRW = 8;
`endif

  logic        CLK = 1'b0;
  logic        RSTN, JTCK, JTDI, JSHIFT, JUPDATE, JRSTN;
  logic [1:0]  JCE, JTDO, cap_we, upd_valid, upd_ready, ovf;
  logic [15:0] cap_data, upd_data;

  int total = 0;
  int bad   = 0;

  jtag_er_bridge #(.NUM_CH(2), .DATA_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .JTCK(JTCK), .JTDI(JTDI), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .JRSTN(JRSTN), .JCE(JCE), .JTDO(JTDO),
    .cap_data(cap_data), .cap_we(cap_we), .upd_data(upd_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tck(input logic shift, input logic tdi);
    @(negedge CLK);
    JSHIFT = shift;
    JTDI   = tdi;
    wait_clk(2);
    JTCK = 1'b1;
    wait_clk(6);
    JTCK = 1'b0;
    wait_clk(6);
  endtask

  task automatic upd_pulse();
    @(negedge CLK);
    JSHIFT  = 1'b0;
    JUPDATE = 1'b1;
    wait_clk(6);
    JUPDATE = 1'b0;
    wait_clk(6);
  endtask

  function automatic logic [SRW-1:0] word(input logic [7:0] v);
`ifdef JTAG_ER_BRIDGE_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  task automatic shift_word(input logic [SRW-1:0] w);
    tck(1'b0, 1'b0);
    for (int i = 0; i < SRW; i++) tck(1'b1, w[i]);
  endtask

  logic [7:0] a5;

  initial begin
    a5 = 8'hA5;
    RSTN = 1'b0; JTCK = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0;
    JRSTN = 1'b1; JCE = 2'b00; cap_data = '0; cap_we = '0; upd_ready = '0;
    wait_clk(4);
    check("rst_jtdo",  64'(JTDO), 64'h0);
    check("rst_valid", 64'(upd_valid), 64'h0);
    check("rst_data",  64'(upd_data), 64'h0);
    check("rst_ovf",   64'(ovf), 64'h0);
    RSTN = 1'b1;
    wait_clk(4);

    // Capture A5 on channel 0 and read it out LSB first.
    cap_data = 16'h00A5; cap_we = 2'b01;
    wait_clk(1);
    cap_we = 2'b00; cap_data = 16'h0000;
    JCE = 2'b01;
    tck(1'b0, 1'b0);
    check("cap_bit0", 64'(JTDO[0]), 64'(a5[0]));
    for (int k = 1; k < 8; k++) begin
      tck(1'b1, 1'b0);
      check($sformatf("cap_bit%0d", k), 64'(JTDO[0]), 64'(a5[k]));
    end
    check("ch1_jtdo_quiet", 64'(JTDO[1]), 64'h0);
    JCE = 2'b00;
    wait_clk(4);

    // Shift 3C into channel 1 and update.
    JCE = 2'b10;
    shift_word(word(8'h3C));
    upd_pulse();
    check("u3c_valid", 64'(upd_valid), 64'h2);
    check("u3c_data1", 64'(upd_data[15:8]), 64'h3C);
    check("u3c_data0", 64'(upd_data[7:0]), 64'h00);
    check("u3c_ovf",   64'(ovf), 64'h0);
    upd_ready = 2'b10;
    wait_clk(1);
    upd_ready = 2'b00;
    check("u3c_drain_valid", 64'(upd_valid), 64'h0);
    check("u3c_drain_data",  64'(upd_data[15:8]), 64'h3C);

    // Two updates without ready: first word kept, overflow raised.
    shift_word(word(8'h11));
    upd_pulse();
    check("u11_valid", 64'(upd_valid), 64'h2);
    check("u11_data",  64'(upd_data[15:8]), 64'h11);
    shift_word(word(8'h22));
    upd_pulse();
    check("u22_keep_old", 64'(upd_data[15:8]), 64'h11);
    check("u22_ovf",      64'(ovf), 64'h2);
    check("u22_valid",    64'(upd_valid), 64'h2);
    upd_ready = 2'b10;
    wait_clk(1);
    upd_ready = 2'b00;
    check("ovf_drain_valid", 64'(upd_valid), 64'h0);
    check("ovf_sticky",      64'(ovf), 64'h2);
    JRSTN = 1'b0;
    wait_clk(4);
    JRSTN = 1'b1;
    wait_clk(4);
    check("jrst_ovf_clear", 64'(ovf), 64'h0);
    // Holding register must survive JTAG reset: capture A5 again.
    JCE = 2'b01;
    tck(1'b0, 1'b0);
    check("jrst_hold_kept", 64'(JTDO[0]), 64'h1);
    JCE = 2'b10;
    wait_clk(4);

    // Update landing on the same edge as the handshake of a pending word.
    shift_word(word(8'h33));
    upd_pulse();
    check("u33_valid", 64'(upd_valid), 64'h2);
    shift_word(word(8'h44));
    @(negedge CLK);
    JSHIFT  = 1'b0;
    JUPDATE = 1'b1;
    wait_clk(2);
    upd_ready = 2'b10;
    wait_clk(1);
    upd_ready = 2'b00;
    wait_clk(3);
    JUPDATE = 1'b0;
    wait_clk(6);
    check("coinc_valid", 64'(upd_valid), 64'h2);
    check("coinc_data",  64'(upd_data[15:8]), 64'h44);
    check("coinc_ovf",   64'(ovf), 64'h0);
    upd_ready = 2'b10;
    wait_clk(1);
    upd_ready = 2'b00;
    check("coinc_drain", 64'(upd_valid), 64'h0);

    // Fabric reset in mid-shift on channel 0.
    JCE = 2'b01;
    tck(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tck(1'b1, 1'b1);
    RSTN = 1'b0;
    wait_clk(2);
    check("mid_rst_jtdo",  64'(JTDO), 64'h0);
    check("mid_rst_valid", 64'(upd_valid), 64'h0);
    check("mid_rst_data",  64'(upd_data), 64'h0);
    check("mid_rst_ovf",   64'(ovf), 64'h0);
    RSTN = 1'b1;
    wait_clk(4);
    upd_pulse();
    check("post_rst_valid", 64'(upd_valid), 64'h0);
    check("post_rst_data",  64'(upd_data), 64'h0);
    tck(1'b0, 1'b0);
    check("post_rst_hold_clr", 64'(JTDO[0]), 64'h0);
    JCE = 2'b00;
    wait_clk(4);

`ifdef JTAG_ER_BRIDGE_PARITY_EN
    // Payload 01 with parity 0 is odd overall: discarded, overflow set.
    JCE = 2'b10;
    shift_word({1'b0, 8'h01});
    upd_pulse();
    check("par_bad_valid", 64'(upd_valid), 64'h0);
    check("par_bad_ovf",   64'(ovf), 64'h2);
    check("par_bad_data",  64'(upd_data[15:8]), 64'h00);
    JCE = 2'b00;
    wait_clk(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
